onchip_mem_loader: RTL and testbench

- Avalon-ST byte-stream to Avalon-MM write master. It sits directly upstream of the 32-bit single-port on-chip RAM (s1 port) and loads it at run time, for example with a boot image streamed from a UART or JTAG bridge.
- Packs incoming bytes little-endian into 32-bit words and writes them at consecutive word addresses.
- Handles partial final words with byteenables, address wrap, and status reporting.

---
 rtl/onchip_mem_loader_if.sv | 41 ++++
 rtl/onchip_mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_onchip_mem_loader.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_loader_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_loader_if
// Groups the byte-stream sink signals and the 32-bit RAM write-master signals
// of onchip_mem_loader.
//   master : the loader's view. It accepts the stream and drives the RAM port.
//   slave  : the environment's view. It drives the stream and start address,
//            and acts as the RAM (returns mem_readdata).
// Stream : start_addr, st_data, st_valid, st_ready, st_sop, st_eop
// RAM    : mem_address, mem_byteenable, mem_chipselect, mem_write,
//          mem_writedata, mem_clken, mem_readdata
// ---------------------------------------------------------------------------
interface onchip_mem_loader_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  start_addr, st_data, st_valid, st_sop, st_eop, mem_readdata,
        output st_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken
    );

    modport slave (
        output start_addr, st_data, st_valid, st_sop, st_eop, mem_readdata,
        input  st_ready, mem_address, mem_byteenable, mem_chipselect, mem_write,
               mem_writedata, mem_clken
    );
endinterface

// File: rtl/onchip_mem_loader.sv
// ---------------------------------------------------------------------------
// onchip_mem_loader
// Byte stream to 32-bit on-chip RAM write master. Bytes are packed
// little-endian into words that are written at consecutive word addresses
// starting from start_addr (sampled on the accepted sop byte). A short final
// word is written with only its filled lanes enabled. The address wraps from
// DEPTH-1 to 0; a wrap with more of the packet still to come sets overflow.
//
// Optional feature (macro ONCHIP_MEM_LOADER_VERIFY_EN): each write is read
// back and compared under its byteenable mask; a mismatch sets verify_err.
// Without the macro verify_err is tied 0 and mem_readdata is ignored.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus            onchip_mem_loader_if.master (stream sink + RAM master)
//   busy           packet in progress
//   done           one-cycle pulse after the eop word is written
//   overflow       sticky: address wrapped within a packet
//   verify_err     sticky: readback mismatch
//   words_written  words written in the current or last packet (saturates)
// ---------------------------------------------------------------------------
module onchip_mem_loader #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 5120
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_loader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                verify_err,
    output logic [ADDR_W:0]     words_written
);

    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StWrite,
        StVerifyRd,
        StVerifyCmp,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   MaxWords = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [2:0]        lane_q, lane_d;    // number of filled lanes, 0..4
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              ovf_q, ovf_d;
    logic              eop_q, eop_d;      // the word being built ends the packet
    logic              rdy_q;             // holds st_ready low until after reset

    logic              accept;
    logic              advance;
    logic              in_write;
    logic              mem_cs;
    logic [3:0]        lane_be;
    logic [4:0]        lane_bit;

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
    logic              verr_q, verr_d;
    logic [31:0]       lane_mask;

    assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
`endif

    assign accept   = bus.st_valid && bus.st_ready;
    assign lane_bit = {lane_q[1:0], 3'b000};

    always_comb begin
        unique case (lane_q)
            3'd1:    lane_be = 4'b0001;
            3'd2:    lane_be = 4'b0011;
            3'd3:    lane_be = 4'b0111;
            3'd4:    lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        addr_d  = addr_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        eop_d   = eop_q;
        advance = 1'b0;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
        verr_d  = verr_q;
`endif

        unique case (state_q)
            StIdle, StPack: begin
                if (accept) begin
                    if (bus.st_sop) begin
                        // New packet, or restart: any partial word is dropped.
                        addr_d  = bus.start_addr;
                        words_d = '0;
                        ovf_d   = 1'b0;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
                        verr_d  = 1'b0;
`endif
                        word_d  = {24'h0, bus.st_data};
                        lane_d  = 3'd1;
                        eop_d   = bus.st_eop;
                        state_d = bus.st_eop ? StWrite : StPack;
                    end else if (state_q == StPack) begin
                        word_d[lane_bit +: 8] = bus.st_data;
                        lane_d = lane_q + 3'd1;
                        eop_d  = bus.st_eop;
                        if (lane_q == 3'd3 || bus.st_eop) begin
                            state_d = StWrite;
                        end
                    end
                end
            end
            StWrite: begin
                if (words_q != MaxWords) begin
                    words_d = words_q + 1'b1;
                end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
                state_d = StVerifyRd;
`else
                advance = 1'b1;
`endif
            end
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
            StVerifyRd: state_d = StVerifyCmp;
            StVerifyCmp: begin
                // Read data arrives the cycle after the read strobe.
                if ((bus.mem_readdata & lane_mask) != (word_q & lane_mask)) begin
                    verr_d = 1'b1;
                end
                advance = 1'b1;
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (advance) begin
            lane_d  = 3'd0;
            word_d  = '0;
            addr_d  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            if (addr_q == LastAddr && !eop_q) begin
                ovf_d = 1'b1;
            end
            state_d = eop_q ? StDone : StPack;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            lane_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            words_q <= '0;
            ovf_q   <= 1'b0;
            eop_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            ovf_q   <= ovf_d;
            eop_q   <= eop_d;
            rdy_q   <= 1'b1;
        end
    end

`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verr_q <= 1'b0;
        end else begin
            verr_q <= verr_d;
        end
    end
    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

    assign in_write = (state_q == StWrite);
    assign mem_cs   = in_write || (state_q == StVerifyRd);

    assign bus.st_ready       = rdy_q && (state_q == StIdle || state_q == StPack);
    assign bus.mem_chipselect = mem_cs;
    assign bus.mem_write      = in_write;
    assign bus.mem_address    = mem_cs ? addr_q : '0;
    assign bus.mem_byteenable = mem_cs ? lane_be : 4'b0000;
    assign bus.mem_writedata  = in_write ? word_q : 32'h0;
    assign bus.mem_clken      = 1'b1;

    assign busy          = (state_q != StIdle) && (state_q != StDone);
    assign done          = (state_q == StDone);
    assign overflow      = ovf_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_onchip_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_loader
// Self-checking bench for onchip_mem_loader: directed packets plus randomized
// packets compared with a byte-level reference model of the loader.
// ---------------------------------------------------------------------------
module tb_onchip_mem_loader;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 5120;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              busy, done, overflow, verify_err;
    logic [ADDR_W:0]   words_written;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    int done_cnt = 0;
    bit corrupt = 1'b0;

    wr_t obs_q[$];
    wr_t exp_q[$];

    // Reference model state
    bit        m_active = 1'b0;
    int        m_addr   = 0;
    int        m_ww     = 0;
    bit        m_ovf    = 1'b0;
    logic [7:0] m_bytes[$];

    onchip_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_mem_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .verify_err   (verify_err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: registered read address, so data follows the read by a cycle.
    logic [31:0] ram [DEPTH];
    logic [31:0] rd_q = 32'h0;
    always @(posedge clk) begin
        if (bus.mem_chipselect && bus.mem_clken) begin
            if (bus.mem_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_byteenable[i]) begin
                        ram[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
                    end
                end
            end else begin
                rd_q <= ram[bus.mem_address];
            end
        end
    end
    assign bus.mem_readdata = rd_q ^ {31'h0, corrupt};

    always @(negedge clk) begin
        if (bus.mem_write && bus.mem_chipselect) begin
            obs_q.push_back('{addr: bus.mem_address, be: bus.mem_byteenable,
                              data: bus.mem_writedata});
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Byte-level model: bytes before a sop are dropped; every 4 bytes or the
    // eop byte makes one write; addresses step by one modulo DEPTH.
    task automatic model_byte(input logic [7:0] d, input logic s, input logic e);
        wr_t w;
        int  n;
        if (s) begin
            m_active = 1'b1;
            m_addr   = int'(bus.start_addr);
            m_bytes.delete();
            m_ww     = 0;
            m_ovf    = 1'b0;
        end
        if (!m_active) return;
        m_bytes.push_back(d);
        if (m_bytes.size() == 4 || e) begin
            n      = m_bytes.size();
            w.addr = ADDR_W'(m_addr);
            w.be   = 4'((1 << n) - 1);
            w.data = 32'h0;
            for (int i = 0; i < n; i++) w.data = w.data | (32'(m_bytes[i]) << (8 * i));
            exp_q.push_back(w);
            if (m_ww < DEPTH) m_ww++;
            m_addr = (m_addr + 1) % DEPTH;
            if (m_addr == 0 && !e) m_ovf = 1'b1;
            m_bytes.delete();
            if (e) m_active = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e, input int gap);
        int n;
        if (gap > 0) begin
            bus.st_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.st_data  = d;
        bus.st_sop   = s;
        bus.st_eop   = e;
        bus.st_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.st_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout st_ready=0 required=1");
        end else begin
            @(posedge clk);
            #1;
            last_acc = cyc;
            model_byte(d, s, e);
        end
        bus.st_valid = 1'b0;
        bus.st_sop   = 1'b0;
        bus.st_eop   = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.st_ready, bus.mem_chipselect, bus.mem_write, busy, done, overflow,
             verify_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=0000000", {bus.st_ready,
                     bus.mem_chipselect, bus.mem_write, busy, done, overflow, verify_err});
        end
        total++;
        if ({bus.mem_address, bus.mem_byteenable, bus.mem_writedata, words_written} !== '0) begin
            bad++;
            $display("FAIL reset_busvals addr=%h be=%h wdata=%h ww=%0d required=0",
                     bus.mem_address, bus.mem_byteenable, bus.mem_writedata, words_written);
        end
        total++;
        if (bus.mem_clken !== 1'b1) begin
            bad++;
            $display("FAIL reset_clken got=%b required=1", bus.mem_clken);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if (bus.st_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ready ready=%b busy=%b required ready=1 busy=0",
                     bus.st_ready, busy);
        end
    endtask

    task automatic test_full_words();
        int  d0 = done_cnt;
        int  w0 = obs_q.size();
        wr_t e0 = '{addr: 13'h10, be: 4'hF, data: 32'h04030201};
        wr_t e1 = '{addr: 13'h11, be: 4'hF, data: 32'h08070605};
        bus.start_addr = 13'h10;
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), i == 0, i == 7, 0);
        wait_done(d0 + 1);
        total++;
        if (obs_q.size() - w0 !== 2) begin
            bad++;
            $display("FAIL full_count got=%0d required=2", obs_q.size() - w0);
        end else begin
            total++;
            if (obs_q[w0] !== e0 || obs_q[w0+1] !== e1) begin
                bad++;
                $display("FAIL full_writes got=%h@%h/%h %h@%h/%h required=04030201@10/f 08070605@11/f",
                         obs_q[w0].data, obs_q[w0].addr, obs_q[w0].be,
                         obs_q[w0+1].data, obs_q[w0+1].addr, obs_q[w0+1].be);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || words_written !== 14'd2) begin
            bad++;
            $display("FAIL full_status done=%0d ww=%0d required done=1 ww=2",
                     done_cnt - d0, words_written);
        end
        total++;
        if (busy !== 1'b0 || bus.st_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_idle busy=%b ready=%b required busy=0 ready=1", busy, bus.st_ready);
        end
    endtask

    task automatic test_partial();
        int  d0 = done_cnt;
        int  w0 = obs_q.size();
        wr_t e1 = '{addr: 13'h1, be: 4'h3, data: 32'h0000A5A4};
        bus.start_addr = 13'h0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), i == 0, i == 5, 0);
        wait_done(d0 + 1);
        total++;
        if (obs_q.size() - w0 !== 2) begin
            bad++;
            $display("FAIL partial_count got=%0d required=2", obs_q.size() - w0);
        end else begin
            total++;
            if (obs_q[w0+1] !== e1) begin
                bad++;
                $display("FAIL partial_write got=%h@%h/%h required=0000a5a4@1/3",
                         obs_q[w0+1].data, obs_q[w0+1].addr, obs_q[w0+1].be);
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL partial_overflow got=%b required=0", overflow);
        end
    endtask

    task automatic test_wrap();
        int d0 = done_cnt;
        int w0 = obs_q.size();
        bus.start_addr = 13'(DEPTH - 1);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), i == 0, i == 7, 0);
        wait_done(d0 + 1);
        total++;
        if (obs_q.size() - w0 !== 2) begin
            bad++;
            $display("FAIL wrap_count got=%0d required=2", obs_q.size() - w0);
        end else begin
            total++;
            if (obs_q[w0].addr !== 13'(DEPTH - 1) || obs_q[w0+1].addr !== 13'h0) begin
                bad++;
                $display("FAIL wrap_addr got=%0d,%0d required=%0d,0",
                         obs_q[w0].addr, obs_q[w0+1].addr, DEPTH - 1);
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL wrap_overflow got=%b required=1", overflow);
        end
    endtask

    task automatic test_no_sop();
        int d0 = done_cnt;
        int w0 = obs_q.size();
        wr_t e0 = '{addr: 13'h55, be: 4'hF, data: 32'h14131211};
        bus.start_addr = 13'h55;
        send_byte(8'hEE, 1'b0, 1'b0, 0);
        send_byte(8'hDD, 1'b0, 1'b1, 1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), i == 0, i == 3, 0);
        wait_done(d0 + 1);
        total++;
        if (obs_q.size() - w0 !== 1) begin
            bad++;
            $display("FAIL nosop_count got=%0d required=1", obs_q.size() - w0);
        end else begin
            total++;
            if (obs_q[w0] !== e0) begin
                bad++;
                $display("FAIL nosop_write got=%h@%h/%h required=14131211@55/f",
                         obs_q[w0].data, obs_q[w0].addr, obs_q[w0].be);
            end
        end
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL nosop_overflow_cleared got=%b required=0", overflow);
        end
    endtask

    task automatic test_reset_mid();
        int  d0;
        int  w0 = obs_q.size();
        wr_t e0 = '{addr: 13'h123, be: 4'hF, data: 32'h24232221};
        bus.start_addr = 13'h40;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h90 + i), i == 0, 1'b0, 0);
        reset_n = 1'b0;
        #2;
        total++;
        if ({bus.st_ready, bus.mem_write, bus.mem_chipselect, busy, done} !== 5'b0 ||
            words_written !== '0 || bus.mem_clken !== 1'b1) begin
            bad++;
            $display("FAIL midreset_outputs rdy/wr/cs/busy/done=%b ww=%0d clken=%b required 00000 0 1",
                     {bus.st_ready, bus.mem_write, bus.mem_chipselect, busy, done},
                     words_written, bus.mem_clken);
        end
        repeat (2) @(posedge clk);
        #1;
        m_active = 1'b0;
        m_bytes.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs_q.size() != w0) begin
            bad++;
            $display("FAIL midreset_nowrite got=%0d writes required=0", obs_q.size() - w0);
        end
        d0 = done_cnt;
        w0 = obs_q.size();
        bus.start_addr = 13'h123;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), i == 0, i == 3, 0);
        wait_done(d0 + 1);
        total++;
        if (obs_q.size() - w0 !== 1 || obs_q[w0] !== e0) begin
            bad++;
            $display("FAIL midreset_next count=%0d required=1 write 24232221@123/f",
                     obs_q.size() - w0);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int first;
        int expd;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
        expd = 10;
`else
        expd = 8;
`endif
        bus.start_addr = 13'h200;
        send_byte(8'h01, 1'b1, 1'b0, 0);
        first = last_acc;
        for (int i = 1; i < 8; i++) send_byte(8'(i + 1), 1'b0, i == 7, 0);
        total++;
        if (last_acc - first !== expd) begin
            bad++;
            $display("FAIL b2b_cycles got=%0d required=%0d", last_acc - first, expd);
        end
        wait_done(d0 + 1);
    endtask

    task automatic test_random();
        for (int p = 0; p < 25; p++) begin
            int d0  = done_cnt;
            int w0  = obs_q.size();
            int e0  = exp_q.size();
            int len = $urandom_range(12, 1);
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(2, 1)) send_byte(8'($urandom), 1'b0, 1'($urandom), 0);
            end
            if ($urandom_range(3) == 0) bus.start_addr = 13'(DEPTH - 1 - $urandom_range(2));
            else bus.start_addr = 13'($urandom_range(DEPTH - 1));
            for (int i = 0; i < len; i++) begin
                logic s = (i == 0) || ($urandom_range(7) == 0);
                send_byte(8'($urandom), s, i == len - 1,
                          ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0);
            end
            wait_done(d0 + 1);
            total++;
            if (obs_q.size() - w0 !== exp_q.size() - e0) begin
                bad++;
                $display("FAIL rand_count pkt=%0d got=%0d required=%0d", p,
                         obs_q.size() - w0, exp_q.size() - e0);
            end else begin
                for (int k = 0; k < exp_q.size() - e0; k++) begin
                    total++;
                    if (obs_q[w0+k] !== exp_q[e0+k]) begin
                        bad++;
                        $display("FAIL rand_write pkt=%0d k=%0d got=%h@%h/%h required=%h@%h/%h",
                                 p, k, obs_q[w0+k].data, obs_q[w0+k].addr, obs_q[w0+k].be,
                                 exp_q[e0+k].data, exp_q[e0+k].addr, exp_q[e0+k].be);
                    end
                end
            end
            total++;
            if (done_cnt - d0 !== 1 || words_written !== 14'(m_ww) || overflow !== m_ovf ||
                verify_err !== 1'b0) begin
                bad++;
                $display("FAIL rand_status pkt=%0d done=%0d ww=%0d ovf=%b verr=%b required 1 %0d %b 0",
                         p, done_cnt - d0, words_written, overflow, verify_err, m_ww, m_ovf);
            end
        end
    endtask

    task automatic test_verify();
        int   d0 = done_cnt;
        logic expv;
`ifdef ONCHIP_MEM_LOADER_VERIFY_EN
        expv = 1'b1;
`else
        expv = 1'b0;
`endif
        corrupt = 1'b1;
        bus.start_addr = 13'h20;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h61 + i), i == 0, i == 3, 0);
        wait_done(d0 + 1);
        corrupt = 1'b0;
        total++;
        if (verify_err !== expv) begin
            bad++;
            $display("FAIL verify_set got=%b required=%b", verify_err, expv);
        end
        send_byte(8'h77, 1'b0, 1'b0, 2);
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (verify_err !== expv) begin
            bad++;
            $display("FAIL verify_sticky got=%b required=%b", verify_err, expv);
        end
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h71 + i), i == 0, i == 3, 0);
        wait_done(d0 + 1);
        total++;
        if (verify_err !== 1'b0) begin
            bad++;
            $display("FAIL verify_clear got=%b required=0", verify_err);
        end
    endtask

    initial begin
        bus.start_addr = '0;
        bus.st_data    = '0;
        bus.st_valid   = 1'b0;
        bus.st_sop     = 1'b0;
        bus.st_eop     = 1'b0;
        test_reset();
        test_full_words();
        test_partial();
        test_wrap();
        test_no_sop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_verify();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
